// File: rtl/dma_desc_sequencer_if.sv
// Sequencer-side register-bus read port plus the outbound 32-bit data stream.
// master = sequencer, slave = bus responder / stream consumer.
interface dma_desc_sequencer_if #(
  parameter int ADDR_BITS = 18
);
  logic                 rd_cyc_o;
  logic [ADDR_BITS-1:0] rd_adr_o;
  logic                 rd_ack_i;
  logic                 rd_err_i;
  logic [31:0]          rd_dat_i;
  logic [31:0]          dout_o;
  logic                 dout_valid_o;
  logic                 dout_last_o;
  logic                 dout_ready_i;

  modport master (
    output rd_cyc_o, rd_adr_o, dout_o, dout_valid_o, dout_last_o,
    input  rd_ack_i, rd_err_i, rd_dat_i, dout_ready_i
  );
  modport slave (
    input  rd_cyc_o, rd_adr_o, dout_o, dout_valid_o, dout_last_o,
    output rd_ack_i, rd_err_i, rd_dat_i, dout_ready_i
  );
endinterface

// File: rtl/dma_desc_sequencer.sv
// Walks a descriptor table, issuing one single-word bus read at a time and
// forwarding each returned word onto a valid/ready stream.
module dma_desc_sequencer #(
  parameter int NUM_DESC  = 32,
  parameter int ADDR_BITS = 18,
  parameter int LEN_BITS  = 12,
  localparam int IW       = $clog2(NUM_DESC)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          desc_wr_i,
  input  logic [IW-1:0] desc_idx_i,
  input  logic [31:0]   desc_dat_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [IW-1:0] cur_desc_o,
  output logic [15:0]   word_cnt_o,
  dma_desc_sequencer_if.master bus
);
  localparam int INC_B = ADDR_BITS;
  localparam int LEN_L = ADDR_BITS + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DESC - 1);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, PUSH, NEXT} state_t;
  state_t state_q, state_d;

  logic [31:0]          mem [NUM_DESC];
  logic [31:0]          desc_q;
  logic [IW-1:0]        idx_q, idx_d, cur_desc_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 inc_q, fin_q, err_q, done_q;
  logic [LEN_BITS:0]    rem_q;
  logic [31:0]          data_q;
  logic [15:0]          word_cnt_q;
  logic [LEN_BITS-1:0]  len_f;
  logic                 last_word;

  assign len_f     = desc_q[LEN_L +: LEN_BITS];
  assign last_word = (rem_q == (LEN_BITS+1)'(1));

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort outranks every event outside IDLE
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && abort_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (start_i) state_d = FETCH;
        FETCH:   state_d = REQ;
        REQ:     if (bus.rd_err_i) state_d = IDLE;
                 else if (bus.rd_ack_i) state_d = PUSH;
        PUSH:    if (bus.dout_ready_i) state_d = last_word ? NEXT : REQ;
        NEXT:    state_d = (fin_q || idx_q == LAST_IDX) ? IDLE : FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy_o           = (state_q != IDLE);
    bus.rd_cyc_o     = (state_q == REQ);
    bus.dout_valid_o = (state_q == PUSH);
    bus.dout_last_o  = (state_q == PUSH) && fin_q && last_word;
  end

  assign bus.rd_adr_o = addr_q;
  assign bus.dout_o   = data_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cur_desc_o   = cur_desc_q;
  assign word_cnt_o   = word_cnt_q;

  // RAM is read with the index of the next cycle so FETCH sees its own slot
  always_comb begin
    idx_d = idx_q;
    if (state_q == IDLE && start_i) idx_d = '0;
    else if (state_q == NEXT && !abort_i && !fin_q && idx_q != LAST_IDX)
      idx_d = idx_q + IW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (desc_wr_i && state_q == IDLE) mem[desc_idx_i] <= desc_dat_i;
    desc_q <= mem[idx_d];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q      <= '0;
      cur_desc_q <= '0;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      fin_q      <= 1'b0;
      rem_q      <= '0;
      data_q     <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          err_q      <= 1'b0;
          word_cnt_q <= '0;
        end
        FETCH: begin
          addr_q     <= desc_q[ADDR_BITS-1:0];
          inc_q      <= desc_q[INC_B];
          fin_q      <= desc_q[31];
          // zero length encodes the full 2^LEN_BITS words
          rem_q      <= (len_f == '0) ? {1'b1, {LEN_BITS{1'b0}}} : {1'b0, len_f};
          cur_desc_q <= idx_q;
        end
        REQ: if (!abort_i) begin
          if (bus.rd_err_i)      err_q  <= 1'b1;
          else if (bus.rd_ack_i) data_q <= bus.rd_dat_i;
        end
        PUSH: if (!abort_i && bus.dout_ready_i) begin
          if (word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
          rem_q <= rem_q - (LEN_BITS+1)'(1);
          if (inc_q) addr_q <= addr_q + ADDR_BITS'(1);
        end
        NEXT: if (!abort_i) begin
          if (fin_q)                  done_q <= 1'b1;
          else if (idx_q == LAST_IDX) err_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_desc_sequencer.sv
// Self-checking bench: directed vector table plus randomized runs, checked
// against a descriptor-walking reference model.
module tb_dma_desc_sequencer;
  localparam int ND = 4;
  localparam int IW = 2;
  localparam int BUDGET = 20000;

  logic          clk_i = 1'b0, rst_n_i = 1'b0;
  logic          desc_wr_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic [IW-1:0] desc_idx_i = '0;
  logic [31:0]   desc_dat_i = '0;
  logic          busy_o, done_o, err_o;
  logic [IW-1:0] cur_desc_o;
  logic [15:0]   word_cnt_o;

  dma_desc_sequencer_if #(.ADDR_BITS(18)) bus ();

  dma_desc_sequencer #(.NUM_DESC(ND), .ADDR_BITS(18), .LEN_BITS(12)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .desc_wr_i(desc_wr_i), .desc_idx_i(desc_idx_i),
    .desc_dat_i(desc_dat_i), .start_i(start_i), .abort_i(abort_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .cur_desc_o(cur_desc_o), .word_cnt_o(word_cnt_o),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ND-1:0][31:0] d;
    bit load, sabort;
    int ack_pct, rdy_pct, err_rd, abort_rd, exp_words;
    bit exp_done, exp_err;
  } vec_t;

  int nchk = 0, nerr = 0;
  logic [17:0] exp_adr[$];
  int          exp_desc[$];
  int          m_words;
  bit          m_done, m_err, m_fin;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  function automatic logic [31:0] mk(logic [17:0] a, bit inc, logic [11:0] len, bit fin);
    return {fin, len, inc, a};
  endfunction

  function automatic vec_t mkv(logic [31:0] d0, d1, d2, d3, bit load, sabort,
                               int ack, rdy, er, ab, words, bit dn, bit e);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.load = load; v.sabort = sabort; v.ack_pct = ack; v.rdy_pct = rdy;
    v.err_rd = er; v.abort_rd = ab; v.exp_words = words; v.exp_done = dn; v.exp_err = e;
    return v;
  endfunction

  // Reference: expand the table into the full list of word reads, then apply
  // the outcome (bus error / abort truncate the run, missing final overruns).
  task automatic model(input vec_t v);
    logic [17:0] a;
    int n;
    bit ovr;
    exp_adr.delete(); exp_desc.delete(); m_fin = 0; ovr = 0;
    for (int s = 0; s < ND; s++) begin
      a = v.d[s][17:0];
      n = (v.d[s][30:19] == '0) ? 4096 : 32'(v.d[s][30:19]);
      for (int k = 0; k < n; k++) begin
        exp_adr.push_back(a); exp_desc.push_back(s);
        if (v.d[s][18]) a = a + 18'd1;
      end
      if (v.d[s][31]) begin m_fin = 1; break; end
      if (s == ND-1) ovr = 1;
    end
    if (v.abort_rd >= 0)    begin m_words = v.abort_rd; m_done = 0; m_err = 0; end
    else if (v.err_rd >= 0) begin m_words = v.err_rd;   m_done = 0; m_err = 1; end
    else begin m_words = exp_adr.size(); m_done = m_fin; m_err = ovr; end
  endtask

  task automatic run(input vec_t v, input string nm);
    int rd_n = 0, wd_n = 0, cyc = 0, dones = 0, ovl = 0, stab = 0, waitc = 0;
    bit held = 0, aborted = 0, exp_v = 0;
    logic [17:0] hadr = '0;
    logic [31:0] dq[$];
    logic [31:0] w;
    model(v);
    if (v.load) for (int s = 0; s < ND; s++) begin
      desc_wr_i = 1; desc_idx_i = IW'(s); desc_dat_i = v.d[s]; step();
    end
    desc_wr_i = 0;
    start_i = 1; abort_i = v.sabort; step(); start_i = 0; abort_i = 0;
    chk({nm, "_start_busy"}, 32'(busy_o), 32'd1);
    chk({nm, "_start_errclr"}, 32'(err_o), 32'd0);
    chk({nm, "_start_wcnt"}, 32'(word_cnt_o), 32'd0);
    step();
    chk({nm, "_lat_rdcyc"}, 32'(bus.rd_cyc_o), 32'd1);
    while (busy_o && cyc < BUDGET) begin
      bus.rd_ack_i = 0; bus.rd_err_i = 0; abort_i = 0; desc_wr_i = 0;
      bus.dout_ready_i = ($urandom_range(0, 99) < 32'(v.rdy_pct));
      if (exp_v) begin chk({nm, "_lat_valid"}, 32'(bus.dout_valid_o), 32'd1); exp_v = 0; end
      if (done_o) dones++;
      if (bus.rd_cyc_o && bus.dout_valid_o) ovl++;
      if (bus.rd_cyc_o) begin
        if (!held) begin
          if (rd_n < exp_adr.size()) begin
            chk({nm, "_rd_adr"}, 32'(bus.rd_adr_o), 32'(exp_adr[rd_n]));
            chk({nm, "_cur_desc"}, 32'(cur_desc_o), 32'(exp_desc[rd_n]));
          end else chk({nm, "_extra_rd"}, 32'(rd_n), 32'(exp_adr.size()));
          held = 1; hadr = bus.rd_adr_o;
        end else if (bus.rd_adr_o != hadr) stab++;
        if (rd_n == v.abort_rd) begin
          // hold off the ack, then abort with an ack in the same cycle
          if (waitc == 2) begin
            abort_i = 1; bus.rd_ack_i = 1; bus.rd_dat_i = $urandom; aborted = 1;
          end
          waitc++;
        end else if ($urandom_range(0, 99) < 32'(v.ack_pct)) begin
          held = 0;
          if (rd_n == v.err_rd) begin
            bus.rd_err_i = 1; bus.rd_ack_i = 1'($urandom_range(0, 1));
          end else begin
            bus.rd_ack_i = 1; bus.rd_dat_i = $urandom; dq.push_back(bus.rd_dat_i); exp_v = 1;
          end
          rd_n++;
        end
      end
      if (bus.dout_valid_o && bus.dout_ready_i) begin
        if (dq.size() == 0) chk({nm, "_extra_word"}, 32'(wd_n), 32'(m_words));
        else begin
          w = dq.pop_front();
          chk({nm, "_dout"}, bus.dout_o, w);
          chk({nm, "_last"}, 32'(bus.dout_last_o), 32'(m_fin && wd_n == exp_adr.size() - 1));
        end
        wd_n++;
      end
      if (cyc == 3) begin desc_wr_i = 1; desc_idx_i = '0; desc_dat_i = mk(18'h3FFFF, 0, 12'd1, 1); end
      step(); cyc++;
    end
    bus.rd_ack_i = 0; bus.rd_err_i = 0; abort_i = 0; desc_wr_i = 0;
    chk({nm, "_end_busy"}, 32'(busy_o), 32'd0);
    if (done_o) dones++;
    chk({nm, "_done_cnt"}, 32'(dones), 32'(v.exp_done));
    chk({nm, "_err"}, 32'(err_o), 32'(v.exp_err));
    chk({nm, "_word_cnt"}, 32'(word_cnt_o), 32'(v.exp_words));
    chk({nm, "_words_seen"}, 32'(wd_n), 32'(v.exp_words));
    chk({nm, "_overlap"}, 32'(ovl), 32'd0);
    chk({nm, "_adr_stable"}, 32'(stab), 32'd0);
    if (aborted) begin
      chk({nm, "_abort_rdcyc"}, 32'(bus.rd_cyc_o), 32'd0);
      chk({nm, "_abort_valid"}, 32'(bus.dout_valid_o), 32'd0);
    end
    step();
    chk({nm, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   mode;
  int   fp;

  initial begin
    logic [31:0] c0, c1;
    bus.rd_ack_i = 0; bus.rd_err_i = 0; bus.rd_dat_i = '0; bus.dout_ready_i = 0;
    c0 = mk(18'h01000, 1, 12'd4, 0);
    c1 = mk(18'h08000, 0, 12'd8, 1);
    vecs[0] = mkv(mk(18'h0C040, 1, 12'd4, 1), 0, 0, 0, 1, 0, 100, 100, -1, -1, 4, 1, 0);
    vecs[1] = mkv(c0, c1, 0, 0, 1, 0, 70, 100, -1, -1, 12, 1, 0);
    vecs[2] = mkv(c0, c1, 0, 0, 0, 1, 60, 33, -1, -1, 12, 1, 0);
    vecs[3] = mkv(c0, c1, 0, 0, 1, 0, 100, 100, 1, -1, 1, 0, 1);
    vecs[4] = mkv(mk(18'h100, 1, 12'd1, 0), mk(18'h200, 1, 12'd1, 0),
                  mk(18'h300, 0, 12'd1, 0), mk(18'h400, 1, 12'd1, 0), 1, 0, 100, 80, -1, -1, 4, 0, 1);
    vecs[5] = mkv(c0, c1, 0, 0, 1, 0, 100, 100, -1, 2, 2, 0, 0);
    vecs[6] = mkv(mk(18'h3FFFE, 1, 12'd0, 1), 0, 0, 0, 1, 0, 100, 100, -1, -1, 4096, 1, 0);
    vecs[7] = mkv(mk(18'h3FFFF, 1, 12'd2, 0), mk(18'h0, 0, 12'd1, 1), 0, 0, 1, 0, 80, 70, -1, -1, 3, 1, 0);

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rdcyc", 32'(bus.rd_cyc_o), 32'd0);
    chk("rst_valid", 32'(bus.dout_valid_o), 32'd0);
    chk("rst_done_err", 32'({done_o, err_o}), 32'd0);
    chk("rst_wcnt", 32'(word_cnt_o), 32'd0);
    #2 rst_n_i = 1;
    step();

    for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Async reset in the middle of a stream push, then a clean restart
    for (int s = 0; s < ND; s++) begin
      desc_wr_i = 1; desc_idx_i = IW'(s); desc_dat_i = vecs[1].d[s]; step();
    end
    desc_wr_i = 0;
    start_i = 1; step(); start_i = 0;
    for (int c = 0; c < 50 && !bus.dout_valid_o; c++) begin
      bus.rd_ack_i = bus.rd_cyc_o; bus.rd_dat_i = 32'h1234_5678; bus.dout_ready_i = 0; step();
    end
    bus.rd_ack_i = 0;
    chk("rstmid_reach_push", 32'(bus.dout_valid_o), 32'd1);
    #2 rst_n_i = 0;
    #1;
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_valid", 32'(bus.dout_valid_o), 32'd0);
    chk("rstmid_dout", bus.dout_o, 32'd0);
    chk("rstmid_rdcyc", 32'(bus.rd_cyc_o), 32'd0);
    chk("rstmid_wcnt", 32'(word_cnt_o), 32'd0);
    chk("rstmid_cur", 32'(cur_desc_o), 32'd0);
    #2 rst_n_i = 1;
    step();
    run(vecs[1], "after_rst");

    for (int r = 0; r < 8; r++) begin
      fp = $urandom_range(0, ND);
      for (int s = 0; s < ND; s++)
        v.d[s] = mk(18'($urandom), 1'($urandom_range(0, 1)), 12'($urandom_range(1, 5)), s == fp);
      v.load = 1; v.sabort = 1'($urandom_range(0, 1));
      v.ack_pct = $urandom_range(30, 100); v.rdy_pct = $urandom_range(30, 100);
      v.err_rd = -1; v.abort_rd = -1;
      model(v);
      mode = $urandom_range(0, 3);
      if (mode == 0) v.err_rd = $urandom_range(0, exp_adr.size() - 1);
      if (mode == 1) v.abort_rd = $urandom_range(0, exp_adr.size() - 1);
      model(v);
      v.exp_words = m_words; v.exp_done = m_done; v.exp_err = m_err;
      run(v, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
